// File: rtl/speicher_pkg.sv
// Shared constants for the memory responder: FSM encoding, channel IDs, wait counter width.
package speicher_pkg;

  localparam logic [1:0] BEREIT  = 2'd0;
  localparam logic [1:0] WARTEN  = 2'd1;
  localparam logic [1:0] ANTWORT = 2'd2;

  typedef logic [1:0] kanal_t;

  // Channel IDs double as bit positions in the request/arming vectors.
  localparam kanal_t KANAL_INSTR     = 2'd0;
  localparam kanal_t KANAL_LESEN     = 2'd1;
  localparam kanal_t KANAL_SCHREIBEN = 2'd2;

  localparam int ZAEHLER_BREITE = 4;

endpackage

// File: rtl/speicher_ram.sv
// Single-port synchronous RAM, 32-bit words, registered read; contents are never reset.
module speicher_ram #(
  parameter int ADRESS_BREITE = 10
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [ADRESS_BREITE-1:0] i_addr,
  input  logic [31:0]              i_din,
  output logic [31:0]              o_dout
);

  logic [31:0] r_mem [2**ADRESS_BREITE];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    o_dout <= r_mem[i_addr];
  end

endmodule

// File: rtl/speicher_antworter.sv
// Memory responder: arbitrates instruction fetch, data load/store and a boot loader onto one RAM,
// inserts WARTEZYKLEN wait cycles and answers each channel with a one-cycle done pulse.
module speicher_antworter
  import speicher_pkg::*;
#(
  parameter int ADRESS_BREITE = 10,
  parameter int WARTEZYKLEN   = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_LeseInstruktion,
  input  logic [31:0] i_InstruktionAdresse,
  input  logic        i_LeseDaten,
  input  logic        i_SchreibeDaten,
  input  logic [31:0] i_DatenAdresse,
  input  logic [31:0] i_DatenRaus,
  input  logic        i_LadeSchreiben,
  input  logic [31:0] i_LadeAdresse,
  input  logic [31:0] i_LadeDaten,
  output logic [31:0] o_Instruktion,
  output logic        o_InstruktionGeladen,
  output logic [31:0] o_DatenRein,
  output logic        o_DatenGeladen,
  output logic        o_DatenGespeichert,
  output logic        o_Fehler
);

  logic [1:0]                r_zustand;
  logic [ZAEHLER_BREITE-1:0] r_zaehler;
  kanal_t                    r_kanal;
  logic [ADRESS_BREITE-1:0]  r_adresse;
  logic [31:0]               r_schreibdaten;
  logic [2:0]                r_armiert;

  logic                      w_bereit;
  logic                      w_lade;
  logic [2:0]                w_anfrage;
  logic [2:0]                w_gueltig;
  logic                      w_annahme;
  kanal_t                    w_kanal;
  logic [31:0]               w_adresse_neu;
  logic                      w_ram_we;
  logic [ADRESS_BREITE-1:0]  w_ram_addr;
  logic [31:0]               w_ram_din;
  logic [31:0]               w_ram_dout;
  logic                      w_unused_adressbits;

  assign w_bereit  = (r_zustand == BEREIT);
  assign w_lade    = w_bereit && i_LadeSchreiben;
  assign w_anfrage = {i_SchreibeDaten, i_LeseDaten, i_LeseInstruktion};
  assign w_gueltig = w_anfrage & r_armiert;
  assign w_annahme = w_bereit && !i_LadeSchreiben && (w_gueltig != 3'b000);

  always_comb begin
    w_kanal       = KANAL_INSTR;
    w_adresse_neu = i_InstruktionAdresse;
    if (w_gueltig[KANAL_SCHREIBEN]) begin
      w_kanal       = KANAL_SCHREIBEN;
      w_adresse_neu = i_DatenAdresse;
    end else if (w_gueltig[KANAL_LESEN]) begin
      w_kanal       = KANAL_LESEN;
      w_adresse_neu = i_DatenAdresse;
    end
  end

  // In BEREIT the RAM already reads the incoming address so the data is ready even with zero wait.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_din  = r_schreibdaten;
    w_ram_addr = r_adresse;
    if (w_lade) begin
      w_ram_we   = 1'b1;
      w_ram_din  = i_LadeDaten;
      w_ram_addr = i_LadeAdresse[ADRESS_BREITE-1:0];
    end else if (w_bereit) begin
      w_ram_addr = w_adresse_neu[ADRESS_BREITE-1:0];
    end else if (r_zustand == ANTWORT && r_kanal == KANAL_SCHREIBEN) begin
      w_ram_we   = 1'b1;
    end
  end

  assign w_unused_adressbits = ^{i_InstruktionAdresse[31:ADRESS_BREITE],
                                 i_DatenAdresse[31:ADRESS_BREITE],
                                 i_LadeAdresse[31:ADRESS_BREITE]};

  speicher_ram #(
    .ADRESS_BREITE (ADRESS_BREITE)
  ) u_ram (
    .i_clk  (i_Clock),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_din  (w_ram_din),
    .o_dout (w_ram_dout)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_zustand            <= BEREIT;
      r_zaehler            <= '0;
      r_kanal              <= KANAL_INSTR;
      r_adresse            <= '0;
      r_schreibdaten       <= '0;
      r_armiert            <= 3'b111;
      o_Instruktion        <= '0;
      o_InstruktionGeladen <= 1'b0;
      o_DatenRein          <= '0;
      o_DatenGeladen       <= 1'b0;
      o_DatenGespeichert   <= 1'b0;
      o_Fehler             <= 1'b0;
    end else begin
      o_InstruktionGeladen <= 1'b0;
      o_DatenGeladen       <= 1'b0;
      o_DatenGespeichert   <= 1'b0;

      for (int k = 0; k < 3; k++) begin
        if (!r_armiert[k] && !w_anfrage[k]) begin
          r_armiert[k] <= 1'b1;
        end
      end

      case (r_zustand)
        BEREIT: begin
          if (w_annahme) begin
            r_kanal        <= w_kanal;
            r_adresse      <= w_adresse_neu[ADRESS_BREITE-1:0];
            r_schreibdaten <= i_DatenRaus;
            r_zaehler      <= '0;
            r_zustand      <= (WARTEZYKLEN == 0) ? ANTWORT : WARTEN;
            // A read colliding with a write is dropped and must be released before it counts again.
            if (w_kanal == KANAL_SCHREIBEN && i_LeseDaten) begin
              o_Fehler               <= 1'b1;
              r_armiert[KANAL_LESEN] <= 1'b0;
            end
          end
        end
        WARTEN: begin
          if (r_zaehler == ZAEHLER_BREITE'(WARTEZYKLEN - 1)) begin
            r_zaehler <= '0;
            r_zustand <= ANTWORT;
          end else begin
            r_zaehler <= r_zaehler + 1'b1;
          end
        end
        ANTWORT: begin
          r_armiert[r_kanal] <= 1'b0;
          r_zustand          <= BEREIT;
          case (r_kanal)
            KANAL_INSTR: begin
              o_InstruktionGeladen <= 1'b1;
              o_Instruktion        <= w_ram_dout;
            end
            KANAL_LESEN: begin
              o_DatenGeladen <= 1'b1;
              o_DatenRein    <= w_ram_dout;
            end
            default: begin
              o_DatenGespeichert <= 1'b1;
            end
          endcase
        end
        default: begin
          r_zustand <= BEREIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speicher_antworter.sv
// Directed self-checking bench for speicher_antworter with hand-computed expectations.
module tb_speicher_antworter;

  localparam int AB = 10;
  localparam int WZ = 2;
  localparam int LATENZ = 2 + WZ;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        leseInstr;
  logic [31:0] instrAdr;
  logic        leseDaten;
  logic        schreibeDaten;
  logic [31:0] datenAdr;
  logic [31:0] datenRaus;
  logic        ladeSchreiben;
  logic [31:0] ladeAdr;
  logic [31:0] ladeDaten;
  logic [31:0] instruktion;
  logic        instrGeladen;
  logic [31:0] datenRein;
  logic        datenGeladen;
  logic        datenGespeichert;
  logic        fehler;

  int errors = 0;
  int checks = 0;
  int instrPulses = 0;
  int readPulses = 0;
  int writePulses = 0;

  speicher_antworter #(
    .ADRESS_BREITE (AB),
    .WARTEZYKLEN   (WZ)
  ) dut (
    .i_Clock              (clk),
    .i_Reset_n            (rst_n),
    .i_LeseInstruktion    (leseInstr),
    .i_InstruktionAdresse (instrAdr),
    .i_LeseDaten          (leseDaten),
    .i_SchreibeDaten      (schreibeDaten),
    .i_DatenAdresse       (datenAdr),
    .i_DatenRaus          (datenRaus),
    .i_LadeSchreiben      (ladeSchreiben),
    .i_LadeAdresse        (ladeAdr),
    .i_LadeDaten          (ladeDaten),
    .o_Instruktion        (instruktion),
    .o_InstruktionGeladen (instrGeladen),
    .o_DatenRein          (datenRein),
    .o_DatenGeladen       (datenGeladen),
    .o_DatenGespeichert   (datenGespeichert),
    .o_Fehler             (fehler)
  );

  always #5 clk = ~clk;

  // Done pulses are counted on the falling edge, well away from the register updates.
  always @(negedge clk) begin
    if (instrGeladen)     instrPulses++;
    if (datenGeladen)     readPulses++;
    if (datenGespeichert) writePulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lInstr, input logic [31:0] iAdr, input logic lRead,
                               input logic lWrite, input logic [31:0] dAdr, input logic [31:0] dOut);
    leseInstr     = lInstr;
    instrAdr      = iAdr;
    leseDaten     = lRead;
    schreibeDaten = lWrite;
    datenAdr      = dAdr;
    datenRaus     = dOut;
  endtask

  task automatic loadWord(input logic [31:0] adr, input logic [31:0] wert);
    ladeSchreiben = 1'b1;
    ladeAdr       = adr;
    ladeDaten     = wert;
    tick();
    ladeSchreiben = 1'b0;
  endtask

  // Counts edges from the current point until the selected done pulse is high; bounded.
  task automatic waitPulse(input int which, input string tag, input int expCycles);
    int  cycles;
    logic seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 30) begin
      tick();
      cycles++;
      case (which)
        0:       seen = instrGeladen;
        1:       seen = datenGeladen;
        default: seen = datenGespeichert;
      endcase
    end
    checkOutput(tag, 64'(cycles), 64'(expCycles));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, {instruktion, datenRein}, 64'h0);
    checkOutput({tag, "_flags"}, 64'({instrGeladen, datenGeladen, datenGespeichert, fehler}), 64'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    ladeSchreiben = 1'b0;
    ladeAdr       = '0;
    ladeDaten     = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    loadWord(32'h010, 32'hDEADBEEF);
    loadWord(32'h040, 32'hCAFEF00D);
    loadWord(32'h005, 32'h00000000);

    // Instruction fetch: latency, value, single pulse while held.
    applyStimulus(1'b1, 32'h010, 1'b0, 1'b0, 32'h0, 32'h0);
    waitPulse(0, "instrLatency", LATENZ);
    checkOutput("instrValue", 64'(instruktion), 64'hDEADBEEF);
    tick();
    checkOutput("instrPulseWidth", 64'(instrGeladen), 64'h0);
    repeat (5) tick();
    checkOutput("instrOnce", 64'(instrPulses), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("instrHold", 64'(instruktion), 64'hDEADBEEF);

    // Store then load the same word.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h020, 32'h12345678);
    waitPulse(2, "writeLatency", LATENZ);
    repeat (3) tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h020, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h020, 32'h0);
    waitPulse(1, "readLatency", LATENZ);
    checkOutput("readValue", 64'(datenRein), 64'h12345678);
    repeat (4) tick();
    checkOutput("writeOnce", 64'(writePulses), 64'd1);
    checkOutput("readOnce", 64'(readPulses), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Simultaneous instruction and data reads: data wins, instruction follows.
    applyStimulus(1'b1, 32'h010, 1'b1, 1'b0, 32'h020, 32'h0);
    waitPulse(1, "prioDataFirst", LATENZ);
    checkOutput("prioInstrNotYet", 64'(instrGeladen), 64'h0);
    waitPulse(0, "prioInstrNext", LATENZ);
    checkOutput("prioInstrValue", 64'(instruktion), 64'hDEADBEEF);
    repeat (5) tick();
    checkOutput("prioReadCount", 64'(readPulses), 64'd2);
    checkOutput("prioInstrCount", 64'(instrPulses), 64'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Read and write together: only the write is served and the error sticks.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h030, 32'hA5A5A5A5);
    waitPulse(2, "collideWrite", LATENZ);
    checkOutput("collideFehler", 64'(fehler), 64'h1);
    repeat (5) tick();
    checkOutput("collideNoRead", 64'(readPulses), 64'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h030, 32'h0);
    waitPulse(1, "collideReadBack", LATENZ);
    checkOutput("collideValue", 64'(datenRein), 64'hA5A5A5A5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fehlerSticky", 64'(fehler), 64'h1);

    // Address wrap: upper bits ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'((1 << AB) + 5), 32'h11111111);
    waitPulse(2, "wrapWrite", LATENZ);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h005, 32'h0);
    waitPulse(1, "wrapRead", LATENZ);
    checkOutput("wrapValue", 64'(datenRein), 64'h11111111);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset during WARTEN of a write: aborted, nothing committed.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h040, 32'h77777777);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h040, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abortNoWrite", 64'(writePulses), 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h040, 32'h0);
    waitPulse(1, "abortReadBack", LATENZ);
    checkOutput("abortRamKept", 64'(datenRein), 64'hCAFEF00D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Request still held across reset release is served exactly once.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h040, 32'h77777777);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    waitPulse(2, "heldAfterReset", LATENZ);
    repeat (5) tick();
    checkOutput("heldOnce", 64'(writePulses), 64'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h040, 32'h0);
    waitPulse(1, "heldReadBack", LATENZ);
    checkOutput("heldValue", 64'(datenRein), 64'h77777777);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
